// File: rtl/alu_sequencer_pkg.sv
// Shared definitions for the ALU sequencer: opcode values (also used by the
// ALU model), instruction field positions, FSM state encoding and decode
// helpers.
package alu_sequencer_pkg;

  // Opcodes. ALU opcodes are forwarded unchanged on alu_inst.
  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_NOT  = 4'd6;
  localparam logic [3:0] OP_SHL  = 4'd7;
  localparam logic [3:0] OP_SHR  = 4'd8;
  localparam logic [3:0] OP_EQ   = 4'd9;
  localparam logic [3:0] OP_LDI  = 4'd10;
  localparam logic [3:0] OP_HALT = 4'd15;

  // Instruction field positions. rs2 and the immediate overlap on purpose:
  // an instruction uses one or the other, never both.
  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 10;
  localparam int RS1_MSB = 9;
  localparam int RS1_LSB = 8;
  localparam int RS2_MSB = 7;
  localparam int RS2_LSB = 6;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

  // FSM state encoding, exported on the dbg_state port.
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_WB     = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  // Coarse instruction classes the sequencer cares about.
  typedef enum logic [1:0] {
    CLS_NOP  = 2'd0,
    CLS_ALU  = 2'd1,
    CLS_LDI  = 2'd2,
    CLS_HALT = 2'd3
  } op_class_t;

  function automatic logic [3:0] ir_opcode(input logic [15:0] ir);
    return ir[OPC_MSB:OPC_LSB];
  endfunction

  function automatic logic [1:0] ir_rd(input logic [15:0] ir);
    return ir[RD_MSB:RD_LSB];
  endfunction

  function automatic logic [1:0] ir_rs1(input logic [15:0] ir);
    return ir[RS1_MSB:RS1_LSB];
  endfunction

  function automatic logic [1:0] ir_rs2(input logic [15:0] ir);
    return ir[RS2_MSB:RS2_LSB];
  endfunction

  function automatic logic [7:0] ir_imm(input logic [15:0] ir);
    return ir[IMM_MSB:IMM_LSB];
  endfunction

  // Opcodes 11-14 are unassigned and behave exactly like NOP.
  function automatic op_class_t classify(input logic [3:0] opc);
    op_class_t cls;
    case (opc)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
      OP_NOT, OP_SHL, OP_SHR, OP_EQ:           cls = CLS_ALU;
      OP_LDI:                                  cls = CLS_LDI;
      OP_HALT:                                 cls = CLS_HALT;
      OP_NOP:                                  cls = CLS_NOP;
      default:                                 cls = CLS_NOP;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/reg_file_4x8.sv
// Four 8-bit general registers: one synchronous write port, two
// combinational operand read ports and a combinational debug read port.
// All registers are real storage; none reads as a constant.
module reg_file_4x8 (
  input  logic       clk,
  input  logic       rst,
  input  logic       we,
  input  logic [1:0] waddr,
  input  logic [7:0] wdata,
  input  logic [1:0] raddr1,
  output logic [7:0] rdata1,
  input  logic [1:0] raddr2,
  output logic [7:0] rdata2,
  input  logic [1:0] dbg_sel,
  output logic [7:0] dbg_data
);

  logic [7:0] regs [4];

  // Register storage: cleared on reset, written on the rising edge when we is set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        regs[i] <= 8'h00;
      end
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  // Read ports are plain muxes, so a write is visible right after its edge.
  always_comb begin
    rdata1   = regs[raddr1];
    rdata2   = regs[raddr2];
    dbg_data = regs[dbg_sel];
  end

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle sequencer that fetches 16-bit instructions from a
// combinational ROM, reads operands from a 4x8 register file, drives an
// external registered ALU and writes its result back.
//
// ALU timing contract: alu_inst/alu_op1/alu_op2 are loaded at the edge that
// closes DECODE and stay stable for the whole EXEC cycle; the ALU samples
// them at the edge that closes EXEC (where alu_inst returns to 0) and its
// registered alu_sol is consumed at the edge that closes WB. alu_inst is
// non-zero only during EXEC; the operands keep their last values otherwise.
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int PC_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  output logic [PC_W-1:0] imem_addr,
  input  logic [15:0]     imem_data,
  output logic [3:0]      alu_inst,
  output logic [7:0]      alu_op1,
  output logic [7:0]      alu_op2,
  input  logic [7:0]      alu_sol,
  output logic            halted,
  input  logic [1:0]      dbg_sel,
  output logic [7:0]      dbg_data,
  output logic [2:0]      dbg_state
);

  localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

  state_t          state_q;
  state_t          state_d;
  logic [PC_W-1:0] pc_q;
  logic [15:0]     ir_q;
  logic [3:0]      inst_q;
  logic [7:0]      op1_q;
  logic [7:0]      op2_q;

  // Control strobes from the output decoder.
  logic            ir_load;
  logic            pc_inc;
  logic            opnd_load;
  logic            inst_clear;
  logic            rf_we;
  logic            rf_from_alu;
  logic            halt_flag;

  // Decoded view of the instruction register.
  op_class_t       op_cls;
  logic [3:0]      ir_opc;
  logic [7:0]      rs1_data;
  logic [7:0]      rs2_data;
  logic [7:0]      rf_wdata;

  assign ir_opc = ir_opcode(ir_q);
  assign op_cls = classify(ir_opc);

  // State register: reset always restarts at FETCH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: the instruction class picked up in DECODE chooses the path.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (op_cls)
          CLS_ALU:  state_d = S_EXEC;
          CLS_HALT: state_d = S_HALT;
          default:  state_d = S_FETCH;
        endcase
      end
      S_EXEC:   state_d = S_WB;
      S_WB:     state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_FETCH;
    endcase
  end

  // Output decoder: one-cycle strobes for the datapath registers below.
  always_comb begin
    ir_load     = 1'b0;
    pc_inc      = 1'b0;
    opnd_load   = 1'b0;
    inst_clear  = 1'b0;
    rf_we       = 1'b0;
    rf_from_alu = 1'b0;
    halt_flag   = 1'b0;
    case (state_q)
      S_FETCH: begin
        ir_load = 1'b1;
        pc_inc  = 1'b1;
      end
      S_DECODE: begin
        opnd_load = (op_cls == CLS_ALU);
        rf_we     = (op_cls == CLS_LDI);
      end
      S_EXEC: begin
        inst_clear = 1'b1;
      end
      S_WB: begin
        rf_we       = 1'b1;
        rf_from_alu = 1'b1;
      end
      S_HALT: begin
        halt_flag = 1'b1;
      end
      default: begin
        halt_flag = 1'b0;
      end
    endcase
  end

  // Program counter: advances once per fetch and wraps modulo 2^PC_W.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= '0;
    end else if (pc_inc) begin
      pc_q <= pc_q + PC_ONE;
    end
  end

  // Instruction register: captures the ROM word presented during FETCH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir_q <= 16'h0000;
    end else if (ir_load) begin
      ir_q <= imem_data;
    end
  end

  // ALU opcode: loaded leaving DECODE, cleared leaving EXEC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst_q <= 4'h0;
    end else if (opnd_load) begin
      inst_q <= ir_opc;
    end else if (inst_clear) begin
      inst_q <= 4'h0;
    end
  end

  // ALU operands: read in DECODE so a later write to rd cannot disturb them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op1_q <= 8'h00;
      op2_q <= 8'h00;
    end else if (opnd_load) begin
      op1_q <= rs1_data;
      op2_q <= rs2_data;
    end
  end

  // Write-back source: ALU result in WB, immediate for LDI in DECODE.
  always_comb begin
    rf_wdata = rf_from_alu ? alu_sol : ir_imm(ir_q);
  end

  reg_file_4x8 u_reg_file (
    .clk      (clk),
    .rst      (rst),
    .we       (rf_we),
    .waddr    (ir_rd(ir_q)),
    .wdata    (rf_wdata),
    .raddr1   (ir_rs1(ir_q)),
    .rdata1   (rs1_data),
    .raddr2   (ir_rs2(ir_q)),
    .rdata2   (rs2_data),
    .dbg_sel  (dbg_sel),
    .dbg_data (dbg_data)
  );

  assign imem_addr = pc_q;
  assign alu_inst  = inst_q;
  assign alu_op1   = op1_q;
  assign alu_op2   = op2_q;
  assign halted    = halt_flag;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: ROM array plus a registered ALU around the DUT,
// an instruction-level reference model that predicts every fetch (pc and
// cycle) and every ALU issue, a monitor that pops and compares them, and
// final register/halt checks per program.
module tb_alu_sequencer;
  import alu_sequencer_pkg::*;

  localparam int PC_W = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [PC_W-1:0] imem_addr;
  logic [15:0]     imem_data;
  logic [3:0]      alu_inst;
  logic [7:0]      alu_op1;
  logic [7:0]      alu_op2;
  logic [7:0]      alu_sol;
  logic            halted;
  logic [1:0]      dbg_sel;
  logic [7:0]      dbg_data;
  logic [2:0]      dbg_state;

  logic [15:0]     rom [256];
  logic [15:0]     prog [$];
  logic [39:0]     fetch_q [$];   // {pc, cycle}
  logic [51:0]     exec_q [$];    // {inst, op1, op2, cycle}
  logic [7:0]      fetch_log [$];
  logic [7:0]      m_reg [4];
  logic [7:0]      m_halt_pc;
  logic [31:0]     cyc;
  logic            mon_en;
  logic [39:0]     fe;
  logic [51:0]     ee;
  int              n_checks = 0;
  int              n_pass = 0;

  alu_sequencer #(.PC_W(PC_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .imem_addr (imem_addr),
    .imem_data (imem_data),
    .alu_inst  (alu_inst),
    .alu_op1   (alu_op1),
    .alu_op2   (alu_op2),
    .alu_sol   (alu_sol),
    .halted    (halted),
    .dbg_sel   (dbg_sel),
    .dbg_data  (dbg_data),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / environment ----------------
  always #5 clk = ~clk;

  assign imem_data = rom[imem_addr];

  function automatic logic [7:0] alu_f(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_NOT:  return ~a;
      OP_SHL:  return a << b;
      OP_SHR:  return a >> b;
      OP_EQ:   return (a == b) ? 8'd1 : 8'd0;
      default: return 8'h00;
    endcase
  endfunction

  // Downstream ALU with a one-cycle registered result.
  always @(posedge clk) alu_sol <= alu_f(alu_inst, alu_op1, alu_op2);

  // Cycle index: 0 is the first FETCH cycle after reset release.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 32'd0;
    else     cyc <= cyc + 32'd1;
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, want, $time);
  endtask

  function automatic logic [15:0] alu_ins(input logic [3:0] op, input logic [1:0] rd,
                                          input logic [1:0] s1, input logic [1:0] s2);
    return {op, rd, s1, s2, 6'b000000};
  endfunction

  function automatic logic [15:0] ldi(input logic [1:0] rd, input logic [7:0] imm);
    return {OP_LDI, rd, 2'b00, imm};
  endfunction

  task automatic read_reg(input logic [1:0] idx, output logic [7:0] v);
    dbg_sel = idx;
    #1;
    v = dbg_data;
  endtask

  // ---------------- reference model ----------------
  // Executes prog in order as an ISA interpreter: ALU ops take 4 cycles with
  // the ALU issue two cycles after the fetch, everything else takes 2.
  task automatic model_run();
    logic [7:0]  pc;
    int          t;
    logic [15:0] w;
    logic [3:0]  op;
    logic [1:0]  rd, s1, s2;
    logic        done;
    pc   = 8'h00;
    t    = 0;
    done = 1'b0;
    for (int i = 0; i < 4; i++) m_reg[i] = 8'h00;
    fetch_q.delete();
    exec_q.delete();
    for (int k = 0; k < prog.size() && !done; k++) begin
      w  = prog[k];
      op = w[15:12];
      rd = w[11:10];
      s1 = w[9:8];
      s2 = w[7:6];
      fetch_q.push_back({pc, 32'(t)});
      pc = pc + 8'd1;
      if (op >= OP_ADD && op <= OP_EQ) begin
        exec_q.push_back({op, m_reg[s1], m_reg[s2], 32'(t + 2)});
        m_reg[rd] = alu_f(op, m_reg[s1], m_reg[s2]);
        t += 4;
      end else if (op == OP_LDI) begin
        m_reg[rd] = w[7:0];
        t += 2;
      end else if (op == OP_HALT) begin
        m_halt_pc = pc;
        done = 1'b1;
      end else begin
        t += 2;
      end
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (dbg_state == S_FETCH) begin
        fetch_log.push_back(imem_addr);
        if (fetch_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_fetch: fetch at pc 0x%0h cycle %0d, none expected", imem_addr, cyc);
        end else begin
          fe = fetch_q.pop_front();
          check("fetch_pc", 32'(imem_addr), 32'(fe[39:32]));
          check("fetch_cycle", cyc, fe[31:0]);
        end
      end
      if (alu_inst != 4'h0) begin
        if (exec_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_alu_inst: alu_inst 0x%0h at cycle %0d, none expected", alu_inst, cyc);
        end else begin
          ee = exec_q.pop_front();
          check("exec_inst", 32'(alu_inst), 32'(ee[51:48]));
          check("exec_op1", 32'(alu_op1), 32'(ee[47:40]));
          check("exec_op2", 32'(alu_op2), 32'(ee[39:32]));
          check("exec_cycle", cyc, ee[31:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_prog();
    mon_en = 1'b0;
    rst    = 1'b1;
    for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
    for (int k = 0; k < prog.size() && k < 256; k++) rom[k] = prog[k];
    fetch_log.delete();
    model_run();
    @(posedge clk);
    #2;
    rst    = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic wait_halt(input string tag);
    int n;
    n = 0;
    while (!halted && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (!halted) $display("timeout waiting for HALT in %s", tag);
    check("halt_reached", 32'(halted), 32'd1);
  endtask

  task automatic finish_prog();
    logic [7:0] v;
    check("fetch_q_drained", 32'(fetch_q.size()), 32'd0);
    check("exec_q_drained", 32'(exec_q.size()), 32'd0);
    for (int i = 0; i < 4; i++) begin
      read_reg(2'(i), v);
      check("reg_vs_model", 32'(v), 32'(m_reg[i]));
    end
  endtask

  task automatic run_prog(input string tag);
    start_prog();
    wait_halt(tag);
    finish_prog();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] v;
    int         n;
    rst     = 1'b1;
    mon_en  = 1'b0;
    dbg_sel = 2'd0;
    for (int i = 0; i < 256; i++) rom[i] = 16'h0000;

    // Reset state.
    @(posedge clk);
    #1;
    check("rst_state", 32'(dbg_state), 32'(S_FETCH));
    check("rst_pc", 32'(imem_addr), 32'd0);
    check("rst_alu_inst", 32'(alu_inst), 32'd0);
    check("rst_op1", 32'(alu_op1), 32'd0);
    check("rst_op2", 32'(alu_op2), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    for (int i = 0; i < 4; i++) begin
      read_reg(2'(i), v);
      check("rst_reg", 32'(v), 32'd0);
    end

    // LDI R1,0x0C; LDI R2,0x05; ADD R3,R1,R2; HALT.
    prog = '{ldi(2'd1, 8'h0C), ldi(2'd2, 8'h05), alu_ins(OP_ADD, 2'd3, 2'd1, 2'd2), 16'hF000};
    run_prog("add");
    read_reg(2'd3, v);
    check("add_r3", 32'(v), 32'h11);

    // SUB R0,R2,R1 wraps; EQ R3,R1,R1.
    prog = '{ldi(2'd1, 8'h0C), ldi(2'd2, 8'h05), alu_ins(OP_SUB, 2'd0, 2'd2, 2'd1),
             alu_ins(OP_EQ, 2'd3, 2'd1, 2'd1), 16'hF000};
    run_prog("sub_eq");
    read_reg(2'd0, v);
    check("sub_r0", 32'(v), 32'hF9);
    read_reg(2'd3, v);
    check("eq_r3", 32'(v), 32'h01);

    // SHL R1,R1,R2 with rs1 == rd.
    prog = '{ldi(2'd1, 8'h01), ldi(2'd2, 8'h03), alu_ins(OP_SHL, 2'd1, 2'd1, 2'd2), 16'hF000};
    run_prog("shl");
    read_reg(2'd1, v);
    check("shl_r1", 32'(v), 32'h08);

    // Opcodes 0 and 12 leave registers alone; HALT freezes pc.
    prog = '{ldi(2'd0, 8'h11), ldi(2'd1, 8'h22), ldi(2'd2, 8'h33), ldi(2'd3, 8'h44),
             16'h0FFF, 16'hCFFF, 16'hF000};
    run_prog("nop_halt");
    for (int i = 0; i < 4; i++) begin
      read_reg(2'(i), v);
      check("nop_reg", 32'(v), 32'(8'h11 * (i + 1)));
    end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("halt_pc_frozen", 32'(imem_addr), 32'h07);
      check("halt_flag", 32'(halted), 32'd1);
    end

    // pc wrap: 256 NOPs, then NOP at 0x00 again, then HALT patched into 0x01.
    prog.delete();
    for (int k = 0; k < 257; k++) prog.push_back(16'h0000);
    prog.push_back(16'hF000);
    start_prog();
    n = 0;
    while (fetch_log.size() < 256 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("wrap_reached_ff", 32'(fetch_log.size() >= 256), 32'd1);
    rom[1] = 16'hF000;
    wait_halt("wrap");
    finish_prog();
    if (fetch_log.size() >= 257) begin
      check("wrap_addr_fe", 32'(fetch_log[254]), 32'hFE);
      check("wrap_addr_ff", 32'(fetch_log[255]), 32'hFF);
      check("wrap_addr_00", 32'(fetch_log[256]), 32'h00);
    end else begin
      n_checks++;
      $display("FAIL wrap_log: got %0d fetches expected at least 257", fetch_log.size());
    end

    // Reset during the EXEC cycle of ADD R3 aborts it.
    prog = '{ldi(2'd1, 8'h0C), ldi(2'd2, 8'h05), alu_ins(OP_ADD, 2'd3, 2'd1, 2'd2), 16'hF000};
    start_prog();
    n = 0;
    while (alu_inst == 4'h0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("exec_reached", 32'(alu_inst), 32'(OP_ADD));
    #1;
    mon_en = 1'b0;
    rst    = 1'b1;
    #1;
    check("abort_state", 32'(dbg_state), 32'(S_FETCH));
    check("abort_pc", 32'(imem_addr), 32'd0);
    check("abort_alu_inst", 32'(alu_inst), 32'd0);
    check("abort_op1", 32'(alu_op1), 32'd0);
    @(posedge clk);
    #1;
    read_reg(2'd3, v);
    check("abort_r3", 32'(v), 32'h00);
    check("abort_state_held", 32'(dbg_state), 32'(S_FETCH));
    // Same program again: first FETCH right at the first edge after release.
    run_prog("after_abort");

    // Randomized programs.
    for (int p = 0; p < 3; p++) begin
      prog.delete();
      for (int k = 0; k < 40; k++) begin
        prog.push_back({4'($urandom_range(0, 14)), 12'($urandom)});
      end
      prog.push_back(16'hF000);
      run_prog("random");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 The block SHALL have parameter PC_W, default 8, meaning instruction address width.
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-003 Port clk  input  1  clock; all state changes on its rising edge.
REQ-004 Port rst  input  1  asynchronous active-high reset.
REQ-005 Port imem_addr  output  PC_W  program counter, driven to the combinational instruction ROM.
REQ-006 Port imem_data  input  16  instruction word at imem_addr, valid in the same cycle.
REQ-007 Port alu_inst  output  4  opcode to the downstream ALU.
REQ-008 Port alu_op1  output  8  ALU operand 1.
REQ-009 Port alu_op2  output  8  ALU operand 2.
REQ-010 Port alu_sol  input  8  ALU result, registered inside the ALU with 1-cycle latency.
REQ-011 Port halted  output  1  high while in HALT.
REQ-012 Port dbg_sel  input  2  register index for the debug read.
REQ-013 Port dbg_data  output  8  combinational read of register dbg_sel.

Function
REQ-014 Instruction format SHALL be [15:12] opcode, [11:10] rd, [9:8] rs1, [7:6] rs2, [7:0] imm.
REQ-015 Opcodes SHALL be: 0 NOP; 1-9 ALU ops (add, sub, and, or, xor, not, shl, shr, eq) passed unchanged on alu_inst; 10 LDI (rd<=imm); 15 HALT; 11-14 treated as NOP.
REQ-016 The FSM SHALL have states FETCH, DECODE, EXEC, WB and HALT.
REQ-017 FETCH: latch imem_data into IR, pc<=pc+1 modulo 2^PC_W (255 wraps to 0), next state DECODE.
REQ-018 DECODE with an ALU op: register alu_op1<=R[rs1], alu_op2<=R[rs2], alu_inst<=opcode, next state EXEC.
REQ-019 DECODE with LDI: R[rd]<=imm at the end of DECODE, next state FETCH.
REQ-020 DECODE with NOP or an invalid opcode: no register write, next state FETCH.
REQ-021 DECODE with HALT: next state HALT.
REQ-022 EXEC: hold alu_inst and the operands stable for the full cycle so the ALU samples them at the closing edge; at that edge alu_inst<=0; next state WB.
REQ-023 WB: R[rd]<=alu_sol at the closing edge, next state FETCH.
REQ-024 alu_inst SHALL be non-zero only during EXEC; alu_op1 and alu_op2 SHALL hold their last values outside EXEC.
REQ-025 Cycle counts SHALL be: ALU op 4 cycles, LDI/NOP/invalid 2 cycles, HALT 2 cycles then stop.
REQ-026 HALT SHALL be absorbing: pc frozen, no register writes, halted=1, exit only via rst.
REQ-027 rs1 and rs2 MAY equal rd; operands SHALL be read in DECODE, before the WB write.
REQ-028 All four registers SHALL be writable; none is hardwired to zero.
REQ-029 dbg_data SHALL reflect a register write from the cycle after the write edge.

Reset
REQ-030 rst high SHALL immediately force state=FETCH, pc=0, IR=0, R0-R3=0, alu_inst=0, alu_op1=0, alu_op2=0, halted=0.
REQ-031 rst asserted mid-instruction (any state, including EXEC or WB) SHALL abort that instruction with no register write.
REQ-032 After rst deasserts, the first FETCH SHALL occur at the first rising edge.

Structure
REQ-033 A shared package SHALL hold the opcode constants (OP_NOP, OP_ADD..OP_EQ, OP_LDI, OP_HALT), the instruction field positions and the FSM state encoding; the ALU SHALL use the same opcode constants.
REQ-034 The register file SHALL be one sub-module, reg_file_4x8: one synchronous write port, two combinational read ports plus the debug read port, asynchronous reset.

Verification
REQ-035 The bench SHALL connect this block to the ALU and a ROM model, and SHALL cover:
- LDI R1,0x0C; LDI R2,0x05; ADD R3,R1,R2 -> R3=0x11, ADD spans exactly 4 cycles, alu_inst=1 only in its EXEC cycle.
- SUB R0,R2,R1 with R1=0x0C, R2=0x05 -> R0=0xF9 (wrap); EQ R3,R1,R1 -> R3=0x01.
- SHL R1,R1,R2 with R1=0x01, R2=0x03 -> R1=0x08 (rs1 equal to rd).
- Opcodes 0 and 12, then HALT -> no register changes; halted=1; pc frozen for 10 cycles.
- pc starting at 0xFE with NOPs -> imem_addr sequence 0xFE, 0xFF, 0x00.
- rst pulsed during the EXEC cycle of ADD R3 -> R3 stays 0x00, pc=0, state=FETCH, alu_inst=0.
